fg_profile_sequencer: RTL and testbench



---
 rtl/fg_profile_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_fg_profile_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fg_profile_sequencer.sv
// -----------------------------------------------------------------------------
// fg_profile_sequencer
//
// Scheduler placed in front of the function generator core. It stores PROFILES
// complete generator configuration words, each with its own dwell count in
// output samples. It then steps the generator through them to produce sweeps
// and bursts without the host being involved.
//
// Ports
//   clk_i, rst_i      clock and synchronous active-high reset
//   wr_en_i           profile memory byte write strobe (accepted only in IDLE)
//   wr_prof_i         profile index for the write
//   wr_byte_i         0-7: config byte (0 = bits 7:0), 8-9: dwell (8 = LSB),
//                     10-15: ignored
//   wr_data_i         write data byte
//   start_i           start the sequence at profile 0
//   stop_i            abort the sequence (highest priority)
//   loop_i            1 = wrap to profile 0 after the last profile (sampled live)
//   last_i            index of the final profile (sampled at start)
//   sample_valid_i    generator output-valid strobe, counted only while running
//   CR_bus_o          config word driven to the generator
//   fg_enable_o       generator enable
//   profile_o         active profile index
//   busy_o            sequence running (LOAD or RUN)
//   done_STRB_o       one-cycle pulse when a non-looping sequence completes
//   wr_err_STRB_o     one-cycle pulse when a write is rejected while busy
// -----------------------------------------------------------------------------
module fg_profile_sequencer #(
    parameter int PROFILES            = 4,
    parameter int CONFIG_REG_BITWIDTH = 64,
    parameter int DWELL_BITWIDTH      = 16,
    parameter int PIDX_W              = $clog2(PROFILES)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           wr_en_i,
    input  logic [PIDX_W-1:0]              wr_prof_i,
    input  logic [3:0]                     wr_byte_i,
    input  logic [7:0]                     wr_data_i,
    input  logic                           start_i,
    input  logic                           stop_i,
    input  logic                           loop_i,
    input  logic [PIDX_W-1:0]              last_i,
    input  logic                           sample_valid_i,
    output logic [CONFIG_REG_BITWIDTH-1:0] CR_bus_o,
    output logic                           fg_enable_o,
    output logic [PIDX_W-1:0]              profile_o,
    output logic                           busy_o,
    output logic                           done_STRB_o,
    output logic                           wr_err_STRB_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t                         state_r;
    state_t                         state_next_s;

    logic [CONFIG_REG_BITWIDTH-1:0] cfg_mem_r   [PROFILES];
    logic [DWELL_BITWIDTH-1:0]      dwell_mem_r [PROFILES];

    logic [DWELL_BITWIDTH-1:0]      dwell_r;
    logic [PIDX_W-1:0]              last_eff_r;
    logic [CONFIG_REG_BITWIDTH-1:0] cr_bus_r;
    logic                           fg_enable_r;
    logic [PIDX_W-1:0]              profile_r;
    logic                           busy_r;
    logic                           done_r;
    logic                           wr_err_r;

    logic [PIDX_W-1:0]              idx_next_s;
    logic                           load_s;
    logic                           done_s;
    logic                           end_prof_s;
    logic                           start_ok_s;

    // A profile ends on the strobe that finds the counter at 1; a counter of 0
    // never reaches 1 and therefore holds the profile until stop.
    assign end_prof_s = (state_r == ST_RUN) && sample_valid_i &&
                        (dwell_r == DWELL_BITWIDTH'(1));
    assign start_ok_s = (state_r == ST_IDLE) && start_i && !stop_i;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: stop wins over end-of-profile, which wins over start.
    always_comb begin
        state_next_s = state_r;
        idx_next_s   = profile_r;
        load_s       = 1'b0;
        done_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) begin
                    state_next_s = ST_LOAD;
                    idx_next_s   = {PIDX_W{1'b0}};
                    load_s       = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (stop_i) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop_i) begin
                    state_next_s = ST_IDLE;
                end else if (end_prof_s) begin
                    if (profile_r != last_eff_r) begin
                        state_next_s = ST_LOAD;
                        idx_next_s   = profile_r + PIDX_W'(1);
                        load_s       = 1'b1;
                    end else if (loop_i) begin
                        state_next_s = ST_LOAD;
                        idx_next_s   = {PIDX_W{1'b0}};
                        load_s       = 1'b1;
                    end else begin
                        state_next_s = ST_IDLE;
                        done_s       = 1'b1;
                    end
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Profile memory: byte writes are accepted only while idle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int p = 0; p < PROFILES; p++) begin
                cfg_mem_r[p]   <= {CONFIG_REG_BITWIDTH{1'b0}};
                dwell_mem_r[p] <= {DWELL_BITWIDTH{1'b0}};
            end
        end else if (wr_en_i && (state_r == ST_IDLE)) begin
            for (int b = 0; b < 8; b++) begin
                if ((wr_byte_i == 4'(b)) && ((b * 8 + 8) <= CONFIG_REG_BITWIDTH)) begin
                    cfg_mem_r[wr_prof_i][b*8 +: 8] <= wr_data_i;
                end
            end
            for (int b = 0; b < 2; b++) begin
                if ((wr_byte_i == 4'(8 + b)) && ((b * 8 + 8) <= DWELL_BITWIDTH)) begin
                    dwell_mem_r[wr_prof_i][b*8 +: 8] <= wr_data_i;
                end
            end
        end
    end

    // Output and datapath registers. The new config word is presented during
    // the LOAD cycle, so it is captured on the transition into LOAD while the
    // enable is still low and the generator timer reloads cleanly.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dwell_r     <= {DWELL_BITWIDTH{1'b0}};
            last_eff_r  <= {PIDX_W{1'b0}};
            cr_bus_r    <= {CONFIG_REG_BITWIDTH{1'b0}};
            fg_enable_r <= 1'b0;
            profile_r   <= {PIDX_W{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            wr_err_r    <= 1'b0;
        end else begin
            fg_enable_r <= (state_next_s == ST_RUN);
            busy_r      <= (state_next_s != ST_IDLE);
            done_r      <= done_s;
            wr_err_r    <= wr_en_i && (state_r != ST_IDLE);
            if (start_ok_s) begin
                last_eff_r <= last_i;
            end
            if (load_s) begin
                cr_bus_r  <= cfg_mem_r[idx_next_s];
                profile_r <= idx_next_s;
                dwell_r   <= dwell_mem_r[idx_next_s];
            end else if ((state_r == ST_RUN) && sample_valid_i &&
                         (dwell_r > DWELL_BITWIDTH'(1))) begin
                dwell_r <= dwell_r - DWELL_BITWIDTH'(1);
            end
        end
    end

    assign CR_bus_o      = cr_bus_r;
    assign fg_enable_o   = fg_enable_r;
    assign profile_o     = profile_r;
    assign busy_o        = busy_r;
    assign done_STRB_o   = done_r;
    assign wr_err_STRB_o = wr_err_r;

endmodule

// File: tb/tb_fg_profile_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fg_profile_sequencer
//
// Self-checking bench for fg_profile_sequencer: a cycle table for the basic
// two-profile sequence, hand-written multi-cycle corner cases, and randomized
// sequences checked against a transaction-level model (the expected list of
// profiles, their config words and their strobe counts).
// -----------------------------------------------------------------------------
module tb_fg_profile_sequencer;

    localparam logic [63:0] C0 = 64'h8000_0000_0000_0011;
    localparam logic [63:0] C1 = 64'h4000_0000_0000_0022;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        wr_en_i;
    logic [1:0]  wr_prof_i;
    logic [3:0]  wr_byte_i;
    logic [7:0]  wr_data_i;
    logic        start_i;
    logic        stop_i;
    logic        loop_i;
    logic [1:0]  last_i;
    logic        sample_valid_i;
    logic [63:0] CR_bus_o;
    logic        fg_enable_o;
    logic [1:0]  profile_o;
    logic        busy_o;
    logic        done_STRB_o;
    logic        wr_err_STRB_o;

    logic [5:0]  flags_s;
    assign flags_s = {fg_enable_o, profile_o, busy_o, done_STRB_o, wr_err_STRB_o};

    int vectors    = 0;
    int miscompares = 0;

    fg_profile_sequencer dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .wr_en_i        (wr_en_i),
        .wr_prof_i      (wr_prof_i),
        .wr_byte_i      (wr_byte_i),
        .wr_data_i      (wr_data_i),
        .start_i        (start_i),
        .stop_i         (stop_i),
        .loop_i         (loop_i),
        .last_i         (last_i),
        .sample_valid_i (sample_valid_i),
        .CR_bus_o       (CR_bus_o),
        .fg_enable_o    (fg_enable_o),
        .profile_o      (profile_o),
        .busy_o         (busy_o),
        .done_STRB_o    (done_STRB_o),
        .wr_err_STRB_o  (wr_err_STRB_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr_en;
        logic        start;
        logic        stop;
        logic        loop;
        logic        sv;
        logic [63:0] cr;
        logic        en;
        logic [1:0]  prof;
        logic        busy;
        logic        done;
        logic        err;
    } vec_t;

    vec_t tbl [21];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wr_byte(input int p, input int b, input logic [7:0] d);
        wr_en_i   = 1'b1;
        wr_prof_i = 2'(p);
        wr_byte_i = 4'(b);
        wr_data_i = d;
        step();
        wr_en_i   = 1'b0;
    endtask

    task automatic wr_profile(input int p, input logic [63:0] cfg, input logic [15:0] dw);
        for (int b = 0; b < 8; b++) begin
            wr_byte(p, b, cfg[b*8 +: 8]);
        end
        wr_byte(p, 8, dw[7:0]);
        wr_byte(p, 9, dw[15:8]);
    endtask

    // Randomized sequence checked against the expected list of segments.
    task automatic rand_run();
        logic [63:0] rc [4];
        logic [15:0] rd [4];
        int last, lp, target, seg, strobes, gap, dones, cyc, ep;
        bit in_seg, sv;
        for (int p = 0; p < 4; p++) begin
            rc[p] = {$urandom, $urandom};
            rd[p] = 16'($urandom_range(1, 5));
            wr_profile(p, rc[p], rd[p]);
        end
        last   = int'($urandom_range(0, 3));
        lp     = int'($urandom_range(0, 1));
        target = (lp != 0) ? 2 * (last + 1) : last + 1;
        last_i = 2'(last);
        loop_i = (lp != 0);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        seg = 0; strobes = 0; gap = 0; dones = 0; cyc = 0; in_seg = 1'b0;
        while (cyc < 400) begin
            stop_i = 1'b0;
            ep = seg % (last + 1);
            if (done_STRB_o) dones++;
            if (fg_enable_o) begin
                if (!in_seg) begin
                    in_seg  = 1'b1;
                    strobes = 0;
                    chk($sformatf("rand seg%0d profile", seg), 64'(profile_o), 64'(ep));
                    chk($sformatf("rand seg%0d cr", seg), CR_bus_o, rc[ep]);
                    chk($sformatf("rand seg%0d gap", seg), 64'(gap), 64'(1));
                    gap = 0;
                end
            end else begin
                if (in_seg) begin
                    in_seg = 1'b0;
                    chk($sformatf("rand seg%0d strobes", seg), 64'(strobes), 64'(rd[ep]));
                    seg++;
                    if ((lp != 0) && (seg == target)) stop_i = 1'b1;
                end
                if (!busy_o) break;
                gap++;
            end
            sv = 1'($urandom_range(0, 1));
            sample_valid_i = sv;
            if (fg_enable_o && sv) strobes++;
            step();
            cyc++;
        end
        stop_i = 1'b0;
        sample_valid_i = 1'b0;
        chk("rand segments", 64'(seg), 64'(target));
        chk("rand done pulses", 64'(dones), 64'((lp != 0) ? 0 : 1));
        chk("rand timeout", 64'(cyc < 400), 64'(1));
    endtask

    initial begin : main
        int cnt, cyc;
        logic seen_done;

        // cycle table: wr_en,start,stop,loop,sv | cr,en,prof,busy,done,err
        tbl[0]  = '{1'b0,1'b1,1'b0,1'b0,1'b0, C0,1'b0,2'd0,1'b1,1'b0,1'b0};
        tbl[1]  = '{1'b0,1'b0,1'b0,1'b0,1'b1, C0,1'b1,2'd0,1'b1,1'b0,1'b0};
        tbl[2]  = '{1'b0,1'b0,1'b0,1'b0,1'b1, C0,1'b1,2'd0,1'b1,1'b0,1'b0};
        tbl[3]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, C0,1'b1,2'd0,1'b1,1'b0,1'b0};
        tbl[4]  = '{1'b0,1'b0,1'b0,1'b0,1'b1, C0,1'b1,2'd0,1'b1,1'b0,1'b0};
        tbl[5]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, C0,1'b1,2'd0,1'b1,1'b0,1'b1};
        tbl[6]  = '{1'b0,1'b0,1'b0,1'b0,1'b1, C1,1'b0,2'd1,1'b1,1'b0,1'b0};
        tbl[7]  = '{1'b0,1'b0,1'b0,1'b0,1'b1, C1,1'b1,2'd1,1'b1,1'b0,1'b0};
        tbl[8]  = '{1'b0,1'b0,1'b0,1'b0,1'b1, C1,1'b1,2'd1,1'b1,1'b0,1'b0};
        tbl[9]  = '{1'b0,1'b1,1'b0,1'b0,1'b0, C1,1'b1,2'd1,1'b1,1'b0,1'b0};
        tbl[10] = '{1'b0,1'b0,1'b0,1'b0,1'b1, C1,1'b0,2'd1,1'b0,1'b1,1'b0};
        tbl[11] = '{1'b0,1'b0,1'b0,1'b0,1'b0, C1,1'b0,2'd1,1'b0,1'b0,1'b0};
        tbl[12] = '{1'b0,1'b1,1'b0,1'b1,1'b0, C0,1'b0,2'd0,1'b1,1'b0,1'b0};
        tbl[13] = '{1'b0,1'b0,1'b0,1'b1,1'b1, C0,1'b1,2'd0,1'b1,1'b0,1'b0};
        tbl[14] = '{1'b0,1'b0,1'b0,1'b1,1'b1, C0,1'b1,2'd0,1'b1,1'b0,1'b0};
        tbl[15] = '{1'b0,1'b0,1'b0,1'b1,1'b1, C0,1'b1,2'd0,1'b1,1'b0,1'b0};
        tbl[16] = '{1'b0,1'b0,1'b0,1'b1,1'b1, C1,1'b0,2'd1,1'b1,1'b0,1'b0};
        tbl[17] = '{1'b0,1'b0,1'b0,1'b1,1'b1, C1,1'b1,2'd1,1'b1,1'b0,1'b0};
        tbl[18] = '{1'b0,1'b0,1'b0,1'b1,1'b1, C1,1'b1,2'd1,1'b1,1'b0,1'b0};
        tbl[19] = '{1'b0,1'b0,1'b0,1'b1,1'b1, C0,1'b0,2'd0,1'b1,1'b0,1'b0};
        tbl[20] = '{1'b0,1'b0,1'b1,1'b1,1'b0, C0,1'b0,2'd0,1'b0,1'b0,1'b0};

        rst_i = 1'b1; wr_en_i = 1'b0; wr_prof_i = 2'd0; wr_byte_i = 4'd0; wr_data_i = 8'd0;
        start_i = 1'b0; stop_i = 1'b0; loop_i = 1'b0; last_i = 2'd0; sample_valid_i = 1'b0;
        repeat (2) step();
        chk("reset cr", CR_bus_o, 64'd0);
        chk("reset flags", 64'(flags_s), 64'(6'b000000));
        rst_i = 1'b0;

        // Empty memory: LOAD then RUN with config 0, dwell 0 holds until stop.
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        chk("empty load flags", 64'(flags_s), 64'(6'b000100));
        chk("empty load cr", CR_bus_o, 64'd0);
        step();
        chk("empty run flags", 64'(flags_s), 64'(6'b100100));
        sample_valid_i = 1'b1;
        repeat (10) step();
        chk("empty hold flags", 64'(flags_s), 64'(6'b100100));
        sample_valid_i = 1'b0;
        stop_i = 1'b1;
        step();
        stop_i = 1'b0;
        chk("empty stop flags", 64'(flags_s), 64'(6'b000000));

        wr_profile(0, C0, 16'd3);
        wr_profile(1, C1, 16'd2);
        wr_byte(0, 12, 8'hFF);
        chk("ignored byte no err", 64'(wr_err_STRB_o), 64'(0));

        // Cycle table: two profiles, rejected write, restart with loop, stop.
        last_i = 2'd1;
        wr_prof_i = 2'd0; wr_byte_i = 4'd0; wr_data_i = 8'hAA;
        for (int i = 0; i < 21; i++) begin
            wr_en_i = tbl[i].wr_en; start_i = tbl[i].start; stop_i = tbl[i].stop;
            loop_i = tbl[i].loop; sample_valid_i = tbl[i].sv;
            step();
            chk($sformatf("tbl[%0d] cr", i), CR_bus_o, tbl[i].cr);
            chk($sformatf("tbl[%0d] flags", i), 64'(flags_s),
                64'({tbl[i].en, tbl[i].prof, tbl[i].busy, tbl[i].done, tbl[i].err}));
        end
        wr_en_i = 1'b0; start_i = 1'b0; stop_i = 1'b0; loop_i = 1'b0; sample_valid_i = 1'b0;

        // Continuous strobes with dwell 1: advance every two cycles.
        for (int p = 0; p < 4; p++) wr_profile(p, 64'h1000 + 64'(p), 16'd1);
        last_i = 2'd3; sample_valid_i = 1'b1; start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("cont k%0d en", k), 64'(fg_enable_o), 64'(k % 2));
            chk($sformatf("cont k%0d prof", k), 64'(profile_o), 64'(k / 2));
            step();
        end
        chk("cont end flags", 64'(flags_s), 64'(6'b011010));
        sample_valid_i = 1'b0;

        // Stop coincident with the final strobe: no done pulse.
        last_i = 2'd0; start_i = 1'b1;
        step();
        start_i = 1'b0;
        step();
        sample_valid_i = 1'b1; stop_i = 1'b1;
        step();
        sample_valid_i = 1'b0; stop_i = 1'b0;
        chk("stop final flags", 64'(flags_s), 64'(6'b000000));
        chk("stop final cr", CR_bus_o, 64'h1000);
        step();
        chk("stop final no done", 64'(done_STRB_o), 64'(0));

        // Reset mid-run clears outputs and the profile memory.
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        chk("midreset cr", CR_bus_o, 64'd0);
        chk("midreset flags", 64'(flags_s), 64'(6'b000000));
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        chk("midreset reload cr", CR_bus_o, 64'd0);
        step();
        sample_valid_i = 1'b1;
        repeat (5) step();
        sample_valid_i = 1'b0;
        chk("midreset dwell0 hold", 64'(flags_s), 64'(6'b100100));
        stop_i = 1'b1;
        step();
        stop_i = 1'b0;

        for (int it = 0; it < 20; it++) rand_run();
        loop_i = 1'b0;

        // Maximum dwell on profile 2: exactly 65535 strobes, then done.
        wr_profile(0, 64'h0A, 16'd1);
        wr_profile(1, 64'h0B, 16'd1);
        wr_profile(2, 64'h0C, 16'hFFFF);
        last_i = 2'd2; sample_valid_i = 1'b1; start_i = 1'b1;
        step();
        start_i = 1'b0;
        cnt = 0; cyc = 0; seen_done = 1'b0;
        while (cyc < 70000) begin
            if (!busy_o) begin
                seen_done = done_STRB_o;
                break;
            end
            if (fg_enable_o && (profile_o == 2'd2)) cnt++;
            step();
            cyc++;
        end
        sample_valid_i = 1'b0;
        chk("maxdwell strobes", 64'(cnt), 64'(65535));
        chk("maxdwell done", 64'(seen_done), 64'(1));
        chk("maxdwell cr", CR_bus_o, 64'h0C);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
